// File: rtl/vga_sync_to_count.sv
// vga_sync_to_count
// Receive-side companion of the VGA sync-pulse generator. It recovers column
// and row counts from a bare HSync/VSync pair. The syncs are active high
// during the visible region. The counts line up with a one-clock-delayed copy
// of the syncs. A small lock state machine checks the line and frame periods:
// it raises o_Locked after enough clean frames in a row and pulses o_SyncErr
// whenever the timing breaks.

module vga_sync_to_count #(
  parameter int c_VISIBLE_COLUMNS = 640,
  parameter int c_VISIBLE_ROWS    = 480,
  parameter int c_TOTAL_COLUMNS   = 800,
  parameter int c_TOTAL_ROWS      = 525,
  parameter int c_LOCK_FRAMES     = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_HSync,
  input  logic       i_VSync,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_ColCount,
  output logic [9:0] o_RowCount,
  output logic       o_FrameStart,
  output logic       o_Locked,
  output logic       o_SyncErr
);

  // A timing set the 10-bit counters or the 4-bit good-frame counter cannot
  // represent is rejected at elaboration instead of silently misbehaving.
  if ((c_TOTAL_COLUMNS > 1024) || (c_TOTAL_ROWS > 1024) ||
      (c_VISIBLE_COLUMNS < 1) || (c_VISIBLE_COLUMNS >= c_TOTAL_COLUMNS) ||
      (c_VISIBLE_ROWS < 1) || (c_VISIBLE_ROWS >= c_TOTAL_ROWS) ||
      (c_LOCK_FRAMES < 1) || (c_LOCK_FRAMES > 15)) begin : g_bad_params
    $error("vga_sync_to_count: unsupported timing parameters");
  end

  localparam logic [9:0] c_COL_LAST    = 10'(c_TOTAL_COLUMNS - 1);
  localparam logic [9:0] c_ROW_LAST    = 10'(c_TOTAL_ROWS - 1);
  localparam logic [3:0] c_LOCK_TARGET = 4'(c_LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_TRACKING,
    ST_LOCKED
  } lock_state_t;

  lock_state_t state;
  logic [3:0]  good_frames;
  logic        frame_clean;

  logic       vrise;
  logic       hrise;
  logic       col_end;
  logic       frame_end;
  logic       sync_err;
  logic [3:0] good_next;

  // The edges are taken against the registered copies. A rise is therefore
  // seen in the same cycle the new level arrives on the input.
  assign vrise     = i_VSync & ~o_VSync;
  assign hrise     = i_HSync & ~o_HSync;
  assign col_end   = (o_ColCount == c_COL_LAST);
  assign frame_end = col_end & (o_RowCount == c_ROW_LAST);

  // Before the first frame edge there is no reference. Timing errors are only
  // judged once the state machine is tracking.
  assign sync_err  = (state != ST_UNLOCKED) &
                     ((hrise & ~col_end) | (vrise & ~frame_end) | (frame_end & ~vrise));

  assign good_next = (good_frames == 4'hF) ? good_frames : good_frames + 4'd1;

  // Delayed sync copies and the single-cycle pulses that are aligned with them
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_HSync      <= 1'b0;
      o_VSync      <= 1'b0;
      o_FrameStart <= 1'b0;
      o_SyncErr    <= 1'b0;
    end else begin
      o_HSync      <= i_HSync;
      o_VSync      <= i_VSync;
      o_FrameStart <= vrise;
      o_SyncErr    <= sync_err;
    end
  end

  // Column/row recovery: free-running modulo counters, re-aligned by every frame edge
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_ColCount <= '0;
      o_RowCount <= '0;
    end else if ((state == ST_UNLOCKED) || vrise) begin
      o_ColCount <= '0;
      o_RowCount <= '0;
    end else if (col_end) begin
      o_ColCount <= '0;
      o_RowCount <= (o_RowCount == c_ROW_LAST) ? 10'd0 : o_RowCount + 10'd1;
    end else begin
      o_ColCount <= o_ColCount + 10'd1;
    end
  end

  // Lock state machine: counts consecutive clean frames and drops lock on any error
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= ST_UNLOCKED;
      good_frames <= '0;
      frame_clean <= 1'b0;
      o_Locked    <= 1'b0;
    end else begin
      case (state)
        ST_UNLOCKED: begin
          o_Locked <= 1'b0;
          if (vrise) begin
            state       <= ST_TRACKING;
            good_frames <= '0;
            frame_clean <= 1'b1;
          end
        end
        ST_TRACKING, ST_LOCKED: begin
          // An error on a frame edge belongs to the frame that is closing. The
          // frame that opens on that edge starts clean.
          if (vrise) begin
            frame_clean <= 1'b1;
          end else if (sync_err) begin
            frame_clean <= 1'b0;
          end

          if (sync_err) begin
            state       <= ST_TRACKING;
            good_frames <= '0;
            o_Locked    <= 1'b0;
          end else if ((state == ST_TRACKING) && vrise && frame_end && frame_clean) begin
            good_frames <= good_next;
            if (good_next == c_LOCK_TARGET) begin
              state    <= ST_LOCKED;
              o_Locked <= 1'b1;
            end
          end
        end
        default: begin
          state       <= ST_UNLOCKED;
          good_frames <= '0;
          frame_clean <= 1'b0;
          o_Locked    <= 1'b0;
        end
      endcase
    end
  end

endmodule
